// File: rtl/exp_1x1_conv_par.sv
// exp_1x1_conv_par: NK-channel parallel 1x1 convolution (multiply, pass/accumulate)
// feeding a first-word-fall-through result FIFO with ready back-pressure.
module exp_1x1_conv_par #(
  parameter int DW    = 8,
  parameter int NK    = 4,
  parameter int GW    = 4,
  parameter int DEPTH = 64
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          start_i,
  input  logic                          acc_mode_i,
  input  logic [15:0]                   acc_len_i,
  input  logic signed [DW-1:0]          layer_data_i,
  input  logic [NK*DW-1:0]              kernel_data_i,
  input  logic                          data_flag_i,
  output logic                          ready_o,
  output logic [NK*(2*DW+GW)-1:0]       fifo_rd_data_o,
  output logic [$clog2(DEPTH):0]        fifo_data_count_o,
  input  logic                          fifo_rd_en_i,
  output logic                          fifo_empty_o,
  output logic                          fifo_full_o,
  output logic                          overflow_o
);
  localparam int AW = 2*DW+GW;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW+1;
  logic                   acc_mode;
  logic [15:0]            acc_len;
  logic [15:0]            cnt;
  logic                   v1;
  logic signed [2*DW-1:0] prod [NK];
  logic                   wr2;
  logic signed [AW-1:0]   acc [NK];
  logic [NK*AW-1:0]       word;
  logic [NK*AW-1:0]       mem [DEPTH];
  logic [PW-1:0]          wptr, rptr;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic                   do_rd, do_wr, last;
  logic [CW:0]            occ;
  always_comb begin
    for (int k = 0; k < NK; k++) word[k*AW +: AW] = acc[k];
  end
  assign last  = cnt == acc_len - 16'd1;
  assign do_rd = !start_i && fifo_rd_en_i && count != '0;
  assign do_wr = !start_i && wr2 && (count != CW'(DEPTH) || do_rd);
  assign occ   = (CW+1)'(count) + (CW+1)'(v1) + (CW+1)'(wr2);
  assign ready_o           = occ < (CW+1)'(DEPTH);
  assign fifo_data_count_o = count;
  assign fifo_empty_o      = count == '0;
  assign fifo_full_o       = count == CW'(DEPTH);
  assign overflow_o        = overflow;
  assign fifo_rd_data_o    = fifo_empty_o ? '0 : mem[rptr];
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      v1 <= 1'b0;
      for (int k = 0; k < NK; k++) prod[k] <= '0;
    end else begin
      v1 <= data_flag_i && !start_i;
      if (data_flag_i && !start_i)
        for (int k = 0; k < NK; k++)
          prod[k] <= layer_data_i * $signed(kernel_data_i[k*DW +: DW]);
    end
  end
  // In pass mode the accumulator simply holds the latest sign-extended product.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_mode <= 1'b0;
      acc_len  <= 16'd1;
      cnt      <= '0;
      wr2      <= 1'b0;
      for (int k = 0; k < NK; k++) acc[k] <= '0;
    end else if (start_i) begin
      acc_mode <= acc_mode_i;
      acc_len  <= (acc_len_i == '0) ? 16'd1 : acc_len_i;
      cnt      <= '0;
      wr2      <= 1'b0;
      for (int k = 0; k < NK; k++) acc[k] <= '0;
    end else begin
      wr2 <= v1 && (!acc_mode || last);
      if (v1) begin
        cnt <= (acc_mode && !last) ? cnt + 16'd1 : '0;
        for (int k = 0; k < NK; k++)
          acc[k] <= (!acc_mode || cnt == '0) ? {{GW{prod[k][2*DW-1]}}, prod[k]}
                                              : acc[k] + {{GW{prod[k][2*DW-1]}}, prod[k]};
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (start_i) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
      if (wr2 && !do_wr) overflow <= 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (do_wr) mem[wptr] <= word;
  end
endmodule

// File: tb/tb_exp_1x1_conv_par.sv
// tb_exp_1x1_conv_par: randomized and directed checks of exp_1x1_conv_par against
// a transaction-level model (products, sums, due-time queue, FIFO queue).
module tb_exp_1x1_conv_par;
  localparam int DW = 8, NK = 4, GW = 4, DEPTH = 8;
  localparam int AW = 2*DW+GW, WW = NK*AW;
  logic clk = 0, rst_n = 0, start = 0, acc_mode = 0, flag = 0, rd_en = 0;
  logic [15:0] acc_len = 0;
  logic signed [DW-1:0] layer = 0;
  logic [NK*DW-1:0] kernel = 0;
  logic ready, empty, full, ovf_o;
  logic [WW-1:0] rd_data;
  logic [$clog2(DEPTH):0] count;
  exp_1x1_conv_par #(.DW(DW), .NK(NK), .GW(GW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .acc_mode_i(acc_mode),
    .acc_len_i(acc_len), .layer_data_i(layer), .kernel_data_i(kernel),
    .data_flag_i(flag), .ready_o(ready), .fifo_rd_data_o(rd_data),
    .fifo_data_count_o(count), .fifo_rd_en_i(rd_en), .fifo_empty_o(empty),
    .fifo_full_o(full), .overflow_o(ovf_o));
  always #5 clk = ~clk;
  typedef struct { int due; logic [WW-1:0] w; } pend_t;
  pend_t pq[$];
  logic [WW-1:0] fq[$];
  int n, mode, alen, cnt, sums[NK];
  bit ovf;
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  function automatic logic [WW-1:0] pack(input int v[NK]);
    logic [WW-1:0] w;
    for (int k = 0; k < NK; k++) w[k*AW +: AW] = v[k][AW-1:0];
    return w;
  endfunction
  task automatic model_reset();
    fq.delete(); pq.delete();
    mode = 0; alen = 1; cnt = 0; ovf = 0;
    for (int k = 0; k < NK; k++) sums[k] = 0;
  endtask
  task automatic step(input logic f, input logic signed [DW-1:0] l, input logic [NK*DW-1:0] kd,
                      input logic r, input logic s, input logic m, input int len);
    int p[NK];
    logic wr;
    logic [WW-1:0] ww;
    logic signed [DW-1:0] kk;
    int due_next;
    flag = f; layer = l; kernel = kd; rd_en = r; start = s; acc_mode = m; acc_len = 16'(len);
    @(posedge clk);
    n++;
    if (s) begin
      model_reset();
      mode = m; alen = (len == 0) ? 1 : len;
    end else begin
      wr = 0; ww = '0;
      if (pq.size() > 0 && pq[0].due == n) begin wr = 1; ww = pq[0].w; void'(pq.pop_front()); end
      if (r && fq.size() > 0) void'(fq.pop_front());
      if (wr) begin
        if (fq.size() < DEPTH) fq.push_back(ww); else ovf = 1;
      end
      if (f) begin
        for (int k = 0; k < NK; k++) begin
          kk = kd[k*DW +: DW];
          p[k] = int'(l) * int'(kk);
        end
        if (mode == 0) pq.push_back('{n+2, pack(p)});
        else begin
          for (int k = 0; k < NK; k++) sums[k] = (cnt == 0) ? p[k] : sums[k] + p[k];
          cnt++;
          if (cnt == alen) begin pq.push_back('{n+2, pack(sums)}); cnt = 0; end
        end
      end
    end
    due_next = (pq.size() > 0 && pq[0].due == n+1) ? 1 : 0;
    #1;
    check("count", WW'(count), WW'(fq.size()));
    check("empty", WW'(empty), WW'(fq.size() == 0));
    check("full", WW'(full), WW'(fq.size() == DEPTH));
    check("overflow", WW'(ovf_o), WW'(ovf));
    check("ready", WW'(ready), WW'((fq.size() + int'(f && !s) + due_next) < DEPTH));
    if (fq.size() > 0) check("head", rd_data, fq[0]);
  endtask
  task automatic idle(input int c);
    for (int i = 0; i < c; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic reset_checks(input string tag);
    check({tag, "_empty"}, WW'(empty), WW'(1));
    check({tag, "_full"}, WW'(full), WW'(0));
    check({tag, "_count"}, WW'(count), WW'(0));
    check({tag, "_ovf"}, WW'(ovf_o), WW'(0));
    check({tag, "_ready"}, WW'(ready), WW'(1));
    check({tag, "_data"}, rd_data, WW'(0));
  endtask
  initial begin
    logic [WW-1:0] e43, e44;
    e43 = {20'hFFE80, 20'd381, 20'hFFFFD, 20'd6};
    e44 = {4{20'd50}};
    model_reset(); n = 0;
    #12 reset_checks("rst");
    #1 rst_n = 1;
    idle(3);
    // pass-mode single strobe, signed boundary weights
    step(1, 3, {8'h80, 8'h7F, 8'hFF, 8'h02}, 0, 0, 0, 0);
    idle(1);
    check("pass_lat", WW'(count), WW'(0));
    idle(1);
    check("pass_cnt", WW'(count), WW'(1));
    check("pass_word", rd_data, e43);
    step(0, 0, 0, 1, 0, 0, 0);
    // accumulate 4 with an idle gap
    step(0, 0, 0, 0, 1, 1, 4);
    step(1, 1, 32'h05050505, 0, 0, 0, 0);
    step(1, 2, 32'h05050505, 0, 0, 0, 0);
    idle(1);
    step(1, 3, 32'h05050505, 0, 0, 0, 0);
    step(1, 4, 32'h05050505, 0, 0, 0, 0);
    idle(1);
    check("acc_lat", WW'(count), WW'(0));
    idle(1);
    check("acc_cnt", WW'(count), WW'(1));
    check("acc_word", rd_data, e44);
    idle(3);
    check("acc_once", WW'(count), WW'(1));
    // fill past DEPTH without reads
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 12; i++) step(1, DW'($urandom), $urandom, 0, 0, 0, 0);
    idle(3);
    check("fill_full", WW'(full), WW'(1));
    check("fill_ovf", WW'(ovf_o), WW'(1));
    check("fill_cnt", WW'(count), WW'(DEPTH));
    // full FIFO: read and write in the same cycle
    step(1, DW'($urandom), $urandom, 0, 0, 0, 0);
    idle(1);
    step(0, 0, 0, 1, 0, 0, 0);
    check("rw_full_cnt", WW'(count), WW'(DEPTH));
    check("rw_full_ovf", WW'(ovf_o), WW'(1));
    // start one cycle after a strobe discards it and reloads config
    step(1, 7, 32'h01020304, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 3);
    idle(3);
    check("start_cnt", WW'(count), WW'(0));
    for (int i = 0; i < 3; i++) step(1, DW'($urandom), $urandom, 0, 0, 0, 0);
    idle(2);
    check("reload_cnt", WW'(count), WW'(1));
    // randomized segments
    for (int sgm = 0; sgm < 8; sgm++) begin
      step(0, 0, 0, 0, 1, 1'($urandom), int'($urandom_range(0, 5)));
      for (int i = 0; i < 80; i++)
        step($urandom_range(0, 9) < 6, DW'($urandom), $urandom, $urandom_range(0, 9) < 4, 0, 0, 0);
    end
    // asynchronous reset with 5 words stored
    step(0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, DW'($urandom), $urandom, 0, 0, 0, 0);
    idle(3);
    check("pre_rst_cnt", WW'(count), WW'(5));
    #2 rst_n = 0;
    #1 reset_checks("arst");
    model_reset();
    #3 rst_n = 1;
    idle(4);
    step(1, 3, {8'h80, 8'h7F, 8'hFF, 8'h02}, 0, 0, 0, 0);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exp_1x1_conv_par.md
EXP_1X1_CONV_PAR -- requirements
Module: exp_1x1_conv_par

Interface
REQ-001 Parameter DW, default 8: signed width of the layer and kernel operands.
REQ-002 Parameter NK, default 4: number of kernels (output channels) processed in parallel.
REQ-003 Parameter GW, default 4: accumulator guard bits; AW = 2*DW+GW is the per-channel result width.
REQ-004 Parameter DEPTH, default 64: output FIFO depth in words; a power of two, at least 8.
REQ-005 clk_i  in  1  single system clock; all state SHALL be updated on its rising edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 start_i  in  1  synchronous clear of pipeline, accumulators, counters, FIFO and sticky flags; samples configuration inputs.
REQ-008 acc_mode_i  in  1  0 = pass mode (one result per input), 1 = accumulate mode; sampled on start_i.
REQ-009 acc_len_i  in  16  inputs per accumulated result; sampled on start_i; a value of 0 SHALL be treated as 1.
REQ-010 layer_data_i  in  DW  signed activation shared by all kernels.
REQ-011 kernel_data_i  in  NK*DW  signed weights; kernel k occupies bits [k*DW +: DW].
REQ-012 data_flag_i  in  1  input-valid strobe; one input per cycle when high.
REQ-013 ready_o  out  1  high when the block can accept input without risk of FIFO overflow.
REQ-014 fifo_rd_data_o  out  NK*AW  FIFO head word; channel k occupies bits [k*AW +: AW].
REQ-015 fifo_data_count_o  out  log2(DEPTH)+1  number of words stored.
REQ-016 fifo_rd_en_i  in  1  read/pop request.
REQ-017 fifo_empty_o  out  1  FIFO empty.
REQ-018 fifo_full_o  out  1  FIFO full.
REQ-019 overflow_o  out  1  sticky flag: a write was dropped because the FIFO was full.

Function
REQ-020 Stage 1 SHALL register the NK signed DW x DW products at full 2*DW width, with no truncation or saturation.
REQ-021 Stage 2 SHALL sign-extend each product to AW bits and either pass it through (pass mode) or add it to that channel's accumulator (accumulate mode).
REQ-022 Stage 3 SHALL write the NK results as one word; in pass mode a data_flag_i at cycle t SHALL produce a write at t+3.
REQ-023 Accumulate mode SHALL use an element counter running 0..acc_len-1.
REQ-024 When the counter is 0, the accumulator SHALL load the new product instead of adding to it.
REQ-025 On the input where the counter reaches acc_len-1, the sum SHALL be written 3 cycles later and the counter SHALL wrap to 0.
REQ-026 Accumulator overflow SHALL wrap modulo 2^AW (two's complement); no saturation.
REQ-027 Idle cycles (data_flag_i low) SHALL NOT advance the counter or alter the accumulators.
REQ-028 ready_o SHALL be low when fifo_data_count_o + (valid entries in stages 1-3) >= DEPTH, and high otherwise.
REQ-029 Inputs arriving while ready_o is low SHALL still be processed.
REQ-030 A write when the FIFO is full with no same-cycle read SHALL be dropped and SHALL set overflow_o.
REQ-031 The FIFO SHALL be first-word-fall-through: fifo_rd_data_o shows the head word whenever fifo_empty_o is low.
REQ-032 A read while empty SHALL be ignored; the count SHALL NOT underflow.
REQ-033 A simultaneous read and write SHALL leave the count unchanged, including when the FIFO is full; the write is then accepted.
REQ-034 The FIFO pointers SHALL wrap modulo DEPTH.
REQ-035 fifo_full_o SHALL be high exactly when the count equals DEPTH.
REQ-036 start_i SHALL take priority over data_flag_i and fifo_rd_en_i in the same cycle; an input presented with start_i SHALL be discarded.
REQ-037 Pipeline entries in flight at start_i SHALL be discarded and SHALL NOT be written to the FIFO.

Reset
REQ-038 Asserting rst_n_i low SHALL clear all state asynchronously, without waiting for a clock edge.
REQ-039 During and after reset: fifo_empty_o=1, fifo_full_o=0, fifo_data_count_o=0, overflow_o=0, ready_o=1, fifo_rd_data_o=0.
REQ-040 After reset, acc_mode=0, acc_len=1, and the counter and accumulators SHALL be 0.
REQ-041 Reset asserted mid-operation SHALL discard in-flight data and FIFO contents.
REQ-042 No write SHALL occur in the first 3 cycles after reset release.

Verification
REQ-043 Pass mode, NK=4, DW=8: layer=3, kernels {2,-1,127,-128}, one strobe at t -> at t+3 one write of {6,-3,381,-384} (AW=20); count goes 0 to 1.
REQ-044 Accumulate mode, acc_len=4: layer 1,2,3,4 with all kernels=5, with an idle cycle between inputs 2 and 3 -> exactly one word {50,50,50,50}, written 3 cycles after input 4.
REQ-045 DEPTH=8, no reads, 12 consecutive strobes -> ready_o low once count+in-flight reaches 8; 8 words stored; fifo_full_o=1; overflow_o=1; first 8 results intact.
REQ-046 Full FIFO, simultaneous read and write -> count stays 8, head advances, overflow_o unchanged.
REQ-047 start_i pulsed 1 cycle after a strobe -> no write occurs; count=0; acc_mode and acc_len reloaded.
REQ-048 rst_n_i dropped asynchronously between clock edges with 5 words stored -> outputs take reset values immediately; fifo_empty_o=1.
